// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions and
// helpers that pack the architected SR/Cause layouts.
package cp0_ctrl_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_BD_BIT = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EC_LO  = 2;
  localparam int CAUSE_EC_HI  = 6;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] r;
    r = '0;
    r[SR_IM_HI:SR_IM_LO] = im;
    r[SR_EXL_BIT]        = exl;
    r[SR_IE_BIT]         = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] ec);
    logic [31:0] r;
    r = '0;
    r[CAUSE_BD_BIT]            = bd;
    r[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
    r[CAUSE_EC_HI:CAUSE_EC_LO] = ec;
    return r;
  endfunction

endpackage

// File: rtl/cp0_req_arb.sv
// Interrupt/exception request arbitration: a masked hardware interrupt beats a
// synchronous exception, and nothing is taken while EXL is set.
module cp0_req_arb
  import cp0_ctrl_pkg::*;
(
  input  logic [5:0] hwint_i,
  input  logic [5:0] sr_im_i,
  input  logic       sr_ie_i,
  input  logic       sr_exl_i,
  input  logic [4:0] exccode_i,
  output logic       take_o,
  output logic       int_req_o,
  output logic [4:0] exccode_o
);

  logic exc_req;

  always_comb begin
    int_req_o = (|(hwint_i & sr_im_i)) & sr_ie_i & ~sr_exl_i;
    exc_req   = (exccode_i != EXC_INT) & ~sr_exl_i;
    take_o    = int_req_o | exc_req;
    exccode_o = int_req_o ? EXC_INT : exccode_i;
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0: SR/Cause/EPC/PrID, exception entry, eret and mfc0/mtc0 from
// the M stage; drives the interrupt request and eret return address to next-PC.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h2019_0707,
  parameter bit          EPC_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_PC,
  input  logic        i_bd,
  input  logic [4:0]  i_exccode,
  input  logic [5:0]  i_hwint,
  input  logic        i_eret,
  output logic [31:0] o_rdata,
  output logic        o_interrupt,
  output logic [31:0] o_epc
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  ec_q, ec_d;
  logic [31:0] epc_q, epc_d;

  logic        take;
  logic        int_req;
  logic [4:0]  sel_code;
  logic [31:0] ret_pc;

  cp0_req_arb u_arb (
    .hwint_i   (i_hwint),
    .sr_im_i   (im_q),
    .sr_ie_i   (ie_q),
    .sr_exl_i  (exl_q),
    .exccode_i (i_exccode),
    .take_o    (take),
    .int_req_o (int_req),
    .exccode_o (sel_code)
  );

  assign o_interrupt = take & reset_n;
  assign ret_pc      = i_bd ? (i_PC - 32'd4) : i_PC;

  // Entry has priority over eret and mtc0 in the same cycle.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ec_d  = ec_q;
    epc_d = epc_q;
    ip_d  = i_hwint;
    if (take) begin
      exl_d = 1'b1;
      ec_d  = sel_code;
      bd_d  = i_bd;
      epc_d = {ret_pc[31:2], 2'b00};
    end else begin
      if (i_eret) exl_d = 1'b0;
      if (i_we) begin
        case (i_addr)
          CP0_SR: begin
            im_d  = i_wdata[SR_IM_HI:SR_IM_LO];
            exl_d = i_wdata[SR_EXL_BIT];
            ie_d  = i_wdata[SR_IE_BIT];
          end
          CP0_EPC: epc_d = {i_wdata[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      ec_q  <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      ec_q  <= ec_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    case (i_addr)
      CP0_SR:    o_rdata = pack_sr(im_q, exl_q, ie_q);
      CP0_CAUSE: o_rdata = pack_cause(bd_q, ip_q, ec_q);
      CP0_EPC:   o_rdata = epc_q;
      CP0_PRID:  o_rdata = PRID;
      default:   o_rdata = '0;
    endcase
  end

  always_comb begin
    if (EPC_BYPASS && i_we && (i_addr == CP0_EPC)) o_epc = {i_wdata[31:2], 2'b00};
    else                                           o_epc = epc_q;
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: the driver queues hand-computed expectations
// per cycle and a negedge monitor compares them against the DUT outputs.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_we;
  logic [4:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] i_PC;
  logic        i_bd;
  logic [4:0]  i_exccode;
  logic [5:0]  i_hwint;
  logic        i_eret;
  logic [31:0] o_rdata;
  logic        o_interrupt;
  logic [31:0] o_epc;

  typedef struct {
    int          kind;   // 0 rdata, 1 interrupt, 2 epc
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  cp0_ctrl #(.PRID(32'h2019_0707), .EPC_BYPASS(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_PC        (i_PC),
    .i_bd        (i_bd),
    .i_exccode   (i_exccode),
    .i_hwint     (i_hwint),
    .i_eret      (i_eret),
    .o_rdata     (o_rdata),
    .o_interrupt (o_interrupt),
    .o_epc       (o_epc)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic bd, input logic [4:0] ec,
                       input logic [5:0] hw, input logic eret);
    @(posedge clk);
    #1;
    i_we = we; i_addr = addr; i_wdata = wdata; i_PC = pc;
    i_bd = bd; i_exccode = ec; i_hwint = hw; i_eret = eret;
  endtask

  task automatic expect_v(input int kind, input string name, input logic [31:0] v);
    exp_t e;
    e.kind = kind; e.name = name; e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [4:0] addr, input logic [5:0] hw, input string name,
                    input logic [31:0] v);
    drive(1'b0, addr, 32'h0, 32'h0, 1'b0, 5'd0, hw, 1'b0);
    expect_v(0, name, v);
    expect_v(1, {name, "_noint"}, 32'h0);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = o_rdata;
        1:       act = {31'h0, o_interrupt};
        default: act = o_epc;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin
    reset_n = 1'b0;
    i_we = 0; i_addr = 0; i_wdata = 0; i_PC = 0; i_bd = 0;
    i_exccode = 0; i_hwint = 0; i_eret = 0;

    // Reset: cleared registers, interrupt suppressed even with a pending request.
    drive(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd12, 6'h3F, 1'b0);
    expect_v(1, "rst_int_forced0", 32'h0);
    expect_v(0, "rst_sr", 32'h0);
    rd(5'd13, 6'h00, "rst_cause", 32'h0);
    rd(5'd14, 6'h00, "rst_epc_rd", 32'h0);
    expect_v(2, "rst_epc_out", 32'h0);
    @(posedge clk); #1; reset_n = 1'b1;

    // Test 1: enable interrupts, then a masked-in line fires.
    drive(1'b1, 5'd12, 32'h0000_FC01, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
    expect_v(1, "t1_wr_noint", 32'h0);
    drive(1'b0, 5'd0, 32'h0, 32'h0000_3000, 1'b0, 5'd0, 6'b000100, 1'b0);
    expect_v(1, "t1_int", 32'h1);
    rd(5'd12, 6'b000100, "t1_sr", 32'h0000_FC03);
    rd(5'd13, 6'h00, "t1_cause", 32'h0000_1000);
    rd(5'd14, 6'h00, "t1_epc", 32'h0000_3000);
    expect_v(2, "t1_epc_out", 32'h0000_3000);
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1);
    expect_v(1, "t1_eret_noint", 32'h0);

    // Test 2: overflow in a delay slot.
    drive(1'b0, 5'd0, 32'h0, 32'h0000_3010, 1'b1, 5'd12, 6'h00, 1'b0);
    expect_v(1, "t2_exc", 32'h1);
    rd(5'd13, 6'h00, "t2_cause", 32'h8000_0030);
    rd(5'd14, 6'h00, "t2_epc", 32'h0000_300C);

    // Test 3: EXL blocks everything, IP still tracks the lines.
    drive(1'b0, 5'd13, 32'h0, 32'h0000_5000, 1'b0, 5'd4, 6'h3F, 1'b0);
    expect_v(1, "t3_blocked", 32'h0);
    expect_v(0, "t3_cause_pre", 32'h8000_0030);
    rd(5'd13, 6'h3F, "t3_cause_ip", 32'h8000_FC30);

    // Test 4: eret with a same-cycle EPC write, forwarded on o_epc.
    drive(1'b1, 5'd14, 32'h0000_3007, 32'h0, 1'b0, 5'd0, 6'h00, 1'b1);
    expect_v(2, "t4_epc_bypass", 32'h0000_3004);
    expect_v(0, "t4_epc_old", 32'h0000_300C);
    expect_v(1, "t4_noint", 32'h0);
    rd(5'd14, 6'h00, "t4_epc_new", 32'h0000_3004);
    expect_v(2, "t4_epc_out", 32'h0000_3004);
    rd(5'd12, 6'h00, "t4_sr_exl0", 32'h0000_FC01);

    // Test 5: interrupt and RI together; interrupt wins, SR write dropped.
    drive(1'b1, 5'd12, 32'h0, 32'h0000_4000, 1'b0, 5'd10, 6'b000001, 1'b0);
    expect_v(1, "t5_int", 32'h1);
    rd(5'd13, 6'h00, "t5_cause", 32'h0000_0400);
    rd(5'd12, 6'h00, "t5_sr", 32'h0000_FC03);
    rd(5'd14, 6'h00, "t5_epc", 32'h0000_4000);

    // Test 6: PrID, unmapped, read-only Cause.
    rd(5'd15, 6'h00, "t6_prid", 32'h2019_0707);
    rd(5'd7, 6'h00, "t6_unmapped", 32'h0);
    drive(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
    drive(1'b1, 5'd15, 32'h1234_5678, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
    drive(1'b1, 5'd7, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
    rd(5'd13, 6'h00, "t6_cause_ro", 32'h0);
    rd(5'd15, 6'h00, "t6_prid_ro", 32'h2019_0707);
    rd(5'd7, 6'h00, "t6_unmapped_wr", 32'h0);

    // Reset mid-handler, then an AdES is taken; the same-cycle EPC write is dropped.
    @(posedge clk); #1; reset_n = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    drive(1'b1, 5'd14, 32'h1234_5678, 32'h0000_5004, 1'b0, 5'd5, 6'h00, 1'b0);
    expect_v(1, "r_exc_after_rst", 32'h1);
    rd(5'd14, 6'h00, "r_epc", 32'h0000_5004);
    rd(5'd13, 6'h00, "r_cause", 32'h0000_0014);
    drive(1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
    rd(5'd12, 6'h00, "r_sr_mask", 32'h0000_FC03);

    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'h00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
